// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: widths, iteration
// count, digit correction constants, FSM state encoding and a digit check.
package bcd_pkg;

    localparam int BCD_W      = 12;
    localparam int BIN_W      = 10;
    localparam int WORK_W     = BCD_W + BIN_W;
    localparam int ITER_N     = 10;
    localparam int CNT_W      = 4;
    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_OFFSET = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // True when any of the three packed digits is outside 0..9.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
        return (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit-field correction step of the reverse double-dabble: after the
// right shift, a field of 8 or more has borrowed a half-ten and loses 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= DIGIT_W'(ADJ_THRESH)) ? (digit_i - DIGIT_W'(ADJ_OFFSET))
                                                        : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Three-digit BCD to 10-bit binary converter. A request is accepted in IDLE,
// the work register is shifted right ten times with per-digit correction,
// and the low ten bits then hold the binary value. Bad digits skip straight
// to DONE with Err raised and BIN untouched.
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [BCD_W-1:0] BCD,
    output logic [BIN_W-1:0] BIN,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;

    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   adjusted;
    logic [DIGIT_W-1:0]  dig_hi, dig_mid, dig_lo;
    logic                last_iter;
    logic                req_bad;

    assign shifted   = work_q >> 1;
    assign last_iter = (cnt_q == CNT_W'(ITER_N - 1));
    assign req_bad   = bcd_invalid(BCD);

    bcd_digit_adj u_adj_hi (
        .digit_i (shifted[WORK_W-1 -: DIGIT_W]),
        .digit_o (dig_hi)
    );

    bcd_digit_adj u_adj_mid (
        .digit_i (shifted[WORK_W-DIGIT_W-1 -: DIGIT_W]),
        .digit_o (dig_mid)
    );

    bcd_digit_adj u_adj_lo (
        .digit_i (shifted[WORK_W-2*DIGIT_W-1 -: DIGIT_W]),
        .digit_o (dig_lo)
    );

    assign adjusted = {dig_hi, dig_mid, dig_lo, shifted[BIN_W-1:0]};

    // State register with asynchronous abort to IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, count ten shifts, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = req_bad ? DONE : SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so Start/BCD never reach them.
    always_comb begin
        Busy = (state_q != IDLE);
        Done = (state_q == DONE);
    end

    // Datapath next values: load on acceptance, shift/correct while in SHIFT.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        err_d  = err_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        work_d = {BCD, {BIN_W{1'b0}}};
                        cnt_d  = '0;
                        err_d  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                work_d = adjusted;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    bin_d = adjusted[BIN_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an aborted run leaves no trace.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            work_q <= '0;
            cnt_q  <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            err_q  <= err_d;
        end
    end

    assign BIN = bin_q;
    assign Err = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: the driver pushes expected results from a
// decimal reference model, a monitor pops and checks them on every Done.
module tb_bcd_to_bin;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic [11:0] BCD;
    logic [9:0]  BIN;
    logic        Busy;
    logic        Done;
    logic        Err;

    typedef struct {
        int bin;
        int err;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_bin = 0;

    bcd_to_bin dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .BCD    (BCD),
        .BIN    (BIN),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: decimal value of the digits, or error if any digit > 9.
    task automatic push_expect(input logic [11:0] bcd, input int ea);
        exp_t e;
        int h, t, o;
        h = int'(bcd[11:8]);
        t = int'(bcd[7:4]);
        o = int'(bcd[3:0]);
        if (h > 9 || t > 9 || o > 9) begin
            e.bin = last_bin;
            e.err = 1;
            e.done_cyc = ea;
        end else begin
            e.bin = h * 100 + t * 10 + o;
            e.err = 0;
            e.done_cyc = ea + 10;
            last_bin = e.bin;
        end
        sb.push_back(e);
    endtask

    // Monitor: every Done must match the head of the scoreboard.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("bin", int'(BIN), e.bin);
                    chk("err", int'(Err), e.err);
                end
            end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                fail_now("missing_done");
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge Clock);
        while ((Busy || Done) && k < 100) begin
            @(negedge Clock);
            k++;
        end
        if (k >= 100) fail_now("idle_timeout");
    endtask

    task automatic do_conv(input logic [11:0] bcd);
        wait_idle();
        Start = 1'b1;
        BCD   = bcd;
        @(posedge Clock);
        #1;
        push_expect(bcd, cyc);
        Start = 1'b0;
        BCD   = 12'($urandom);
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
                0:       v[11:8] = 4'($urandom_range(10, 15));
                1:       v[7:4]  = 4'($urandom_range(10, 15));
                default: v[3:0]  = 4'($urandom_range(10, 15));
            endcase
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int ea;
        Resetn = 1'b0;
        Start  = 1'b0;
        BCD    = '0;
        repeat (3) @(negedge Clock);
        chk("rst_bin", int'(BIN), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_err", int'(Err), 0);
        Resetn = 1'b1;

        // Full-scale conversion and busy window length.
        do_conv(12'h999);
        b = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clock);
            if (Busy) b++;
            else break;
        end
        chk("busy_len", b, 11);

        do_conv(12'h255);
        do_conv(12'h000);
        do_conv(12'h255);
        do_conv(12'h1A3);
        do_conv(12'h010);

        // Start re-pulsed mid-conversion with new data must be ignored.
        do_conv(12'h123);
        repeat (4) @(posedge Clock);
        #1;
        Start = 1'b1;
        BCD   = 12'h456;
        @(posedge Clock);
        #1;
        Start = 1'b0;

        // Reset at edge 6 aborts the conversion without a Done.
        do_conv(12'h777);
        repeat (6) @(posedge Clock);
        #2;
        Resetn = 1'b0;
        sb.delete();
        last_bin = 0;
        #1;
        chk("abort_bin", int'(BIN), 0);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        chk("abort_err", int'(Err), 0);
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        do_conv(12'h042);

        // Start held high: a new request every 12 edges, all giving 500.
        wait_idle();
        Start = 1'b1;
        BCD   = 12'h500;
        @(posedge Clock);
        #1;
        ea = cyc;
        for (int k = 0; k < 3; k++) push_expect(12'h500, ea + 12 * k);
        repeat (25) @(posedge Clock);
        #1;
        Start = 1'b0;

        // Randomised mix of valid and invalid requests.
        for (int n = 0; n < 40; n++) do_conv(rand_bcd());

        b = 0;
        while (sb.size() > 0 && b < 200) begin
            @(negedge Clock);
            b++;
        end
        if (b >= 200) fail_now("drain_timeout");
        repeat (3) @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
